// File: rtl/genpc_pkg.sv
// Shared constants, types and width helpers for the fetch PC generator.
// Latency: n/a (package).
// Backpressure: n/a (package).
package genpc_pkg;

    // Sequential PC increments for compressed and full-width instructions.
    localparam logic [31:0] INC_RV16 = 32'd2;
    localparam logic [31:0] INC_RV32 = 32'd4;

    // Link registers recognised by the call/return hints.
    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    typedef enum logic {
        ST_SEQ   = 1'b0,
        ST_CROSS = 1'b1
    } fsm_state_t;

    // Byte-offset width inside a fetch block.
    function automatic int calc_ob(input int fetch_bytes);
        return $clog2(fetch_bytes);
    endfunction

    // RAS pointer width; never below 1 bit.
    function automatic int calc_ras_pw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop, replace-top; count saturates at DEPTH.
// Latency: updates visible at top/empty on the cycle after the edge.
// Backpressure: none; push when full overwrites oldest, pop when empty is ignored.
// Ports: clk/rst, push/pop strobes, push_dat; top = newest entry, empty = count 0.
module ras_stack
    import genpc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_dat,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PW = calc_ras_pw(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW:0]   cnt;

    logic do_push;
    logic do_pop;
    logic do_repl;

    assign do_push = push & ~pop;
    assign do_pop  = pop & ~push & (cnt != '0);
    // Coroutine call/return: new link replaces the popped one in place.
    assign do_repl = push & pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp  <= '0;
            cnt <= '0;
        end else if (do_push) begin
            sp <= sp + PW'(1);
            if (cnt != (PW+1)'(DEPTH)) begin
                cnt <= cnt + (PW+1)'(1);
            end
        end else if (do_pop) begin
            sp  <= sp - PW'(1);
            cnt <= cnt - (PW+1)'(1);
        end
    end

    // Storage is not reset; count gates every read that matters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push) begin
                mem[sp + PW'(1)] <= push_dat;
            end else if (do_repl) begin
                mem[sp] <= push_dat;
            end
        end
    end

    assign top   = mem[sp];
    assign empty = (cnt == '0);

endmodule

// File: rtl/genpc_ras.sv
// Fetch PC generator with return-address stack and cross-block two-read FSM.
// Latency: nxtpc/isram_adr/isram_cs combinational; pc registered, 1 cycle.
// Backpressure: stall or fet_stall holds pc; CROSS costs one extra cycle.
// Ports: redirect/trap/decode hints in; pc, isram_adr/cs, cross_bd_ff, fet_stall,
// ras_pred, ras_empty out.
module genpc_ras
    import genpc_pkg::*;
#(
    parameter int FETCH_BYTES = 8,
    parameter int RAS_DEPTH   = 4,
    localparam int OB         = calc_ob(FETCH_BYTES)
) (
    input  logic          clk,
    input  logic          cpurst,
    input  logic [31:0]   boot_addr,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          trap_valid,
    input  logic [31:0]   trap_pc,
    input  logic          dec_valid,
    input  logic          dec_isrv16,
    input  logic          dec_isjal,
    input  logic          dec_isjalr,
    input  logic          dec_isbxx,
    input  logic          dec_bxx_taken,
    input  logic [31:0]   dec_offset,
    input  logic          dec_rd_link,
    input  logic          dec_rs1_link,
    input  logic [31:0]   jalr_base,
    input  logic          jalr_dep,
    output logic [31:0]   pc,
    output logic [31-OB:0] isram_adr,
    output logic          isram_cs,
    output logic          cross_bd_ff,
    output logic          fet_stall,
    output logic          ras_pred,
    output logic          ras_empty
);
    fsm_state_t    state_q, state_d;
    logic [31:0]   nxtpc;
    logic [31:0]   inc;
    logic [31:0]   ras_top;
    logic          st_empty;
    logic          ret, call, adv, jc, last_hw;
    logic [31-OB:0] adr_ff;

    assign ret  = dec_isjalr & dec_rs1_link & ~dec_rd_link;
    assign call = (dec_isjal | dec_isjalr) & dec_rd_link;
    assign inc  = dec_isrv16 ? INC_RV16 : INC_RV32;

    assign cross_bd_ff = (state_q == ST_CROSS);

    // A predicted return never waits on the forwarded base register.
    assign fet_stall = ~cpurst &
                       ((dec_valid & dec_isjalr & jalr_dep & ~(ret & ~st_empty)) | cross_bd_ff);
    assign ras_empty = cpurst | st_empty;

    always_comb begin
        nxtpc    = pc + inc;
        jc       = 1'b0;
        ras_pred = 1'b0;
        if (redirect_valid) begin
            nxtpc = redirect_pc;
            jc    = 1'b1;
        end else if (stall | fet_stall) begin
            nxtpc = pc;
        end else if (trap_valid) begin
            nxtpc = trap_pc;
            jc    = 1'b1;
        end else if (dec_valid & ret & ~st_empty) begin
            nxtpc    = (ras_top + dec_offset) & ~32'd1;
            jc       = 1'b1;
            ras_pred = 1'b1;
        end else if (dec_valid & dec_isjalr) begin
            nxtpc = (jalr_base + dec_offset) & ~32'd1;
            jc    = 1'b1;
        end else if (dec_valid & (dec_isjal | (dec_isbxx & dec_bxx_taken))) begin
            nxtpc = pc + dec_offset;
            jc    = 1'b1;
        end
    end

    // Target sits in the last halfword of its block: a 32-bit instruction there
    // straddles into the next block.
    assign last_hw = &nxtpc[OB-1:1];

    assign adv = dec_valid & ~redirect_valid & ~trap_valid & ~stall & ~fet_stall;

    ras_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (cpurst),
        .push     (adv & call),
        .pop      (adv & ret),
        .push_dat (pc + inc),
        .top      (ras_top),
        .empty    (st_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEQ:   if (last_hw & jc & ~stall) state_d = ST_CROSS;
            ST_CROSS: state_d = ST_SEQ;
            default:  state_d = ST_SEQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state_q <= ST_SEQ;
            pc      <= boot_addr;
            adr_ff  <= boot_addr[31:OB];
        end else begin
            state_q <= state_d;
            pc      <= nxtpc;
            adr_ff  <= isram_adr;
        end
    end

    always_comb begin
        isram_adr = nxtpc[31:OB];
        if (cpurst) begin
            isram_adr = boot_addr[31:OB];
        end else if (cross_bd_ff & ~redirect_valid) begin
            isram_adr = pc[31:OB] + 1'b1;
        end else if (last_hw & ~jc) begin
            // Lower half already buffered on sequential arrival: prefetch next block.
            isram_adr = pc[31:OB] + 1'b1;
        end
    end

    assign isram_cs = cpurst | (isram_adr != adr_ff) | (last_hw & (isram_adr == adr_ff));

endmodule

// File: tb/tb_genpc_ras.sv
module tb_genpc_ras;
    logic        clk = 1'b0;
    logic        cpurst;
    logic [31:0] boot_addr;
    logic        stall, redirect_valid, trap_valid;
    logic [31:0] redirect_pc, trap_pc;
    logic        dec_valid, dec_isrv16, dec_isjal, dec_isjalr, dec_isbxx, dec_bxx_taken;
    logic [31:0] dec_offset, jalr_base;
    logic        dec_rd_link, dec_rs1_link, jalr_dep;

    logic [31:0] pc8, pc16;
    logic [28:0] adr8;
    logic [27:0] adr16;
    logic        cs8, cross8, fst8, pred8, emp8;
    logic        cs16, cross16, fst16, pred16, emp16;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    genpc_ras #(.FETCH_BYTES(8), .RAS_DEPTH(4)) dut (
        .clk(clk), .cpurst(cpurst), .boot_addr(boot_addr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .dec_valid(dec_valid),
        .dec_isrv16(dec_isrv16), .dec_isjal(dec_isjal), .dec_isjalr(dec_isjalr),
        .dec_isbxx(dec_isbxx), .dec_bxx_taken(dec_bxx_taken), .dec_offset(dec_offset),
        .dec_rd_link(dec_rd_link), .dec_rs1_link(dec_rs1_link), .jalr_base(jalr_base),
        .jalr_dep(jalr_dep), .pc(pc8), .isram_adr(adr8), .isram_cs(cs8),
        .cross_bd_ff(cross8), .fet_stall(fst8), .ras_pred(pred8), .ras_empty(emp8)
    );

    genpc_ras #(.FETCH_BYTES(16), .RAS_DEPTH(4)) dut16 (
        .clk(clk), .cpurst(cpurst), .boot_addr(boot_addr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .dec_valid(dec_valid),
        .dec_isrv16(dec_isrv16), .dec_isjal(dec_isjal), .dec_isjalr(dec_isjalr),
        .dec_isbxx(dec_isbxx), .dec_bxx_taken(dec_bxx_taken), .dec_offset(dec_offset),
        .dec_rd_link(dec_rd_link), .dec_rs1_link(dec_rs1_link), .jalr_base(jalr_base),
        .jalr_dep(jalr_dep), .pc(pc16), .isram_adr(adr16), .isram_cs(cs16),
        .cross_bd_ff(cross16), .fet_stall(fst16), .ras_pred(pred16), .ras_empty(emp16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Plain sequential 32-bit fetch with all side channels quiet.
    task automatic idle();
        stall = 0; redirect_valid = 0; trap_valid = 0;
        dec_valid = 1; dec_isrv16 = 0; dec_isjal = 0; dec_isjalr = 0;
        dec_isbxx = 0; dec_bxx_taken = 0; dec_offset = 0;
        dec_rd_link = 0; dec_rs1_link = 0; jalr_dep = 0;
    endtask

    task automatic redir(input logic [31:0] a);
        idle();
        redirect_valid = 1; redirect_pc = a;
        tick();
        idle();
    endtask

    task automatic jal(input logic [31:0] off, input logic link);
        idle();
        dec_isjal = 1; dec_offset = off; dec_rd_link = link;
    endtask

    task automatic retn(input logic dep, input logic [31:0] base);
        idle();
        dec_isjalr = 1; dec_rs1_link = 1; jalr_dep = dep; jalr_base = base;
    endtask

    logic [31:0] exp_ret [4] = '{32'h344, 32'h334, 32'h324, 32'h314};

    initial begin
        idle();
        redirect_pc = 0; trap_pc = 0; jalr_base = 0;
        boot_addr = 32'h100;
        cpurst = 1;

        // Reset
        tick();
        mid();
        chk("rst_cs", {31'd0, cs8}, 1);
        chk("rst_fst", {31'd0, fst8}, 0);
        chk("rst_empty", {31'd0, emp8}, 1);
        chk("rst_adr", {3'd0, adr8}, 32'h20);
        tick();
        cpurst = 0;
        chk("rst_pc", pc8, 32'h100);

        // Sequential fetch
        mid();
        chk("seq0_adr", {3'd0, adr8}, 32'h20);
        chk("seq0_cs", {31'd0, cs8}, 0);
        tick();
        chk("seq1_pc", pc8, 32'h104);
        mid();
        chk("seq1_adr", {3'd0, adr8}, 32'h21);
        chk("seq1_cs", {31'd0, cs8}, 1);
        tick();
        chk("seq2_pc", pc8, 32'h108);
        mid();
        chk("seq2_cs", {31'd0, cs8}, 0);

        // Cross-block jump to 0x10E
        redir(32'h100);
        chk("xb_pc0", pc8, 32'h100);
        jal(32'hE, 0);
        mid();
        chk("xb_adr0", {3'd0, adr8}, 32'h21);
        chk("xb_cs0", {31'd0, cs8}, 1);
        tick();
        idle();
        chk("xb_cross", {31'd0, cross8}, 1);
        chk("xb_pc1", pc8, 32'h10E);
        mid();
        chk("xb_adr1", {3'd0, adr8}, 32'h22);
        chk("xb_fst", {31'd0, fst8}, 1);
        tick();
        chk("xb_seq", {31'd0, cross8}, 0);
        chk("xb_pc2", pc8, 32'h10E);

        // Call then predicted return
        redir(32'h200);
        jal(32'h40, 1);
        mid();
        chk("call_empty0", {31'd0, emp8}, 1);
        tick();
        chk("call_pc", pc8, 32'h240);
        chk("call_empty1", {31'd0, emp8}, 0);
        retn(1, 32'hDEAD);
        mid();
        chk("ret_pred", {31'd0, pred8}, 1);
        chk("ret_fst", {31'd0, fst8}, 0);
        chk("ret_adr", {3'd0, adr8}, 32'h40);
        tick();
        chk("ret_pc", pc8, 32'h204);
        chk("ret_empty", {31'd0, emp8}, 1);
        retn(1, 32'h301);
        mid();
        chk("dep_fst", {31'd0, fst8}, 1);
        chk("dep_pred", {31'd0, pred8}, 0);
        tick();
        chk("dep_hold", pc8, 32'h204);
        jalr_dep = 0;
        tick();
        chk("jalr_pc", pc8, 32'h300);

        // Overflow: five calls, four LIFO returns, fifth ret uses jalr_base
        for (int i = 0; i < 5; i++) begin
            jal(32'h10, 1);
            tick();
        end
        chk("ovf_pc", pc8, 32'h350);
        for (int i = 0; i < 4; i++) begin
            retn(1, 32'hBAD0);
            mid();
            chk($sformatf("pop%0d_pred", i), {31'd0, pred8}, 1);
            tick();
            chk($sformatf("pop%0d_pc", i), pc8, exp_ret[i]);
        end
        chk("unf_empty0", {31'd0, emp8}, 1);
        retn(0, 32'h500);
        mid();
        chk("unf_pred", {31'd0, pred8}, 0);
        tick();
        chk("unf_pc", pc8, 32'h500);
        chk("unf_empty1", {31'd0, emp8}, 1);

        // Priority: redirect beats stall and trap; trap beats decode
        idle();
        redirect_valid = 1; redirect_pc = 32'h400;
        trap_valid = 1; trap_pc = 32'h480; stall = 1;
        tick();
        chk("prio_redir", pc8, 32'h400);
        idle();
        stall = 1;
        tick();
        chk("prio_stall", pc8, 32'h400);
        idle();
        trap_valid = 1; trap_pc = 32'h480;
        dec_isjal = 1; dec_offset = 32'h40;
        tick();
        chk("prio_trap", pc8, 32'h480);

        // Redirect during CROSS
        redir(32'h100);
        jal(32'hE, 0);
        tick();
        idle();
        chk("xr_cross", {31'd0, cross8}, 1);
        redirect_valid = 1; redirect_pc = 32'h600;
        mid();
        chk("xr_adr", {3'd0, adr8}, 32'hC0);
        tick();
        idle();
        chk("xr_seq", {31'd0, cross8}, 0);
        chk("xr_pc", pc8, 32'h600);

        // Stalled call does not push until it advances
        jal(32'h20, 1);
        stall = 1;
        tick();
        chk("sc_pc", pc8, 32'h600);
        chk("sc_empty", {31'd0, emp8}, 1);
        stall = 0;
        tick();
        chk("sc_pc2", pc8, 32'h620);
        chk("sc_push", {31'd0, emp8}, 0);

        // Reset in CROSS with a non-empty RAS
        redir(32'h100);
        jal(32'hE, 0);
        tick();
        idle();
        chk("rc_cross", {31'd0, cross8}, 1);
        cpurst = 1;
        mid();
        chk("rc_fst", {31'd0, fst8}, 0);
        chk("rc_cs", {31'd0, cs8}, 1);
        chk("rc_empty", {31'd0, emp8}, 1);
        tick();
        cpurst = 0;
        chk("rc_seq", {31'd0, cross8}, 0);
        chk("rc_pc", pc8, 32'h100);
        chk("rc_empty2", {31'd0, emp8}, 1);

        // 16-byte blocks: 0x11E crosses in both builds, 0x116 only in 8-byte
        jal(32'h1E, 0);
        tick();
        idle();
        chk("p16_cross_11e", {31'd0, cross16}, 1);
        chk("p8_cross_11e", {31'd0, cross8}, 1);
        tick();
        chk("p16_pc", pc16, 32'h11E);
        redir(32'h100);
        jal(32'h16, 0);
        tick();
        idle();
        chk("p16_cross_116", {31'd0, cross16}, 0);
        chk("p8_cross_116", {31'd0, cross8}, 1);
        chk("p16_pc2", pc16, 32'h116);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
